// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, LSB-first serialisation,
// bit period set by CLKS_PER_BIT. The line and all status outputs come from flops.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_end;

  assign baud_end = (baud_q == CNT_MAX);

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = CNT_W'(baud_q + 1'b1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Line follows the bit that becomes shift_reg[0] after this shift
            bit_d   = 3'(bit_q + 3'd1);
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = CNT_W'(baud_q + 1'b1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          baud_d = CNT_W'(baud_q + 1'b1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at N=4, one at N=2, checked every
// cycle of each frame against the 8N1 line timing.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] d4, d2;
  logic       v4, v2;
  logic       rdy4, tx4, busy4, done4;
  logic       rdy2, tx2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_a, done_b;

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(d4), .tx_valid(v4),
    .tx_ready(rdy4), .tx(tx4), .tx_busy(busy4), .tx_done(done4)
  );

  uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(rdy2), .tx(tx2), .tx_busy(busy2), .tx_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one byte from a negedge, then checks every cycle E0..E0+10N.
  // hold keeps tx_valid high; pulse_k injects a 0x81 request seen at edge E0+pulse_k.
  task automatic frame(input bit sel, input int n, input logic [7:0] d,
                       input bit hold, input int pulse_k, output int done_cyc);
    logic e_tx;
    logic o_tx, o_rdy, o_busy, o_done;
    done_cyc = -1;
    if (sel) begin d2 = d; v2 = 1'b1; end
    else     begin d4 = d; v4 = 1'b1; end
    @(posedge clk);
    for (int k = 0; k <= 10 * n; k++) begin
      @(negedge clk);
      if (!hold) begin
        if (sel) v2 = 1'b0; else v4 = 1'b0;
      end
      if (k == pulse_k - 1) begin d4 = 8'h81; v4 = 1'b1; end
      if (k < n)          e_tx = 1'b0;
      else if (k < 9 * n) e_tx = d[k / n - 1];
      else                e_tx = 1'b1;
      o_tx   = sel ? tx2   : tx4;
      o_rdy  = sel ? rdy2  : rdy4;
      o_busy = sel ? busy2 : busy4;
      o_done = sel ? done2 : done4;
      chk($sformatf("tx d=%02h k=%0d", d, k), 32'(o_tx), 32'(e_tx));
      chk($sformatf("done d=%02h k=%0d", d, k), 32'(o_done), 32'(k == 10 * n));
      chk($sformatf("ready d=%02h k=%0d", d, k), 32'(o_rdy), 32'(k == 10 * n));
      chk($sformatf("busy d=%02h k=%0d", d, k), 32'(o_busy), 32'(k != 10 * n));
      if (k == 10 * n) done_cyc = cyc;
      if (k < 10 * n) @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d4 = 8'hFF; d2 = 8'hFF;
    v4 = 1'b1;  v2 = 1'b1;

    // Reset held with tx_valid asserted: outputs must stay at idle values
    repeat (4) begin
      @(negedge clk);
      chk("rst tx", 32'(tx4), 32'd1);
      chk("rst ready", 32'(rdy4), 32'd1);
      chk("rst busy", 32'(busy4), 32'd0);
      chk("rst done", 32'(done4), 32'd0);
      chk("rst tx2", 32'(tx2), 32'd1);
    end
    v4 = 1'b0; v2 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle tx", 32'(tx4), 32'd1);

    // Single byte 0xA5
    frame(1'b0, 4, 8'hA5, 1'b0, -1, done_a);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    frame(1'b0, 4, 8'h00, 1'b1, -1, done_a);
    frame(1'b0, 4, 8'hFF, 1'b1, -1, done_b);
    v4 = 1'b0;
    chk("b2b done gap", 32'(done_b - done_a), 32'd41);

    // Request during busy must be dropped
    @(negedge clk);
    frame(1'b0, 4, 8'h3C, 1'b0, 10, done_a);
    repeat (20) begin
      @(negedge clk);
      chk("ignore tx", 32'(tx4), 32'd1);
      chk("ignore done", 32'(done4), 32'd0);
      chk("ignore ready", 32'(rdy4), 32'd1);
    end

    // Mid-frame asynchronous reset inside data bit 3
    d4 = 8'hF7; v4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      v4 = 1'b0;
      if (k < 16) @(posedge clk);
    end
    chk("pre-reset bit3", 32'(tx4), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst tx", 32'(tx4), 32'd1);
    chk("async rst ready", 32'(rdy4), 32'd1);
    chk("async rst busy", 32'(busy4), 32'd0);
    chk("async rst done", 32'(done4), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("in rst done", 32'(done4), 32'd0);
      chk("in rst tx", 32'(tx4), 32'd1);
    end
    rst_n = 1'b1;
    frame(1'b0, 4, 8'h5A, 1'b0, -1, done_a);

    // Smallest divider
    @(negedge clk);
    frame(1'b1, 2, 8'h01, 1'b0, -1, done_a);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
